// File: rtl/keypad_pkg.sv
// Shared encodings for the 4x4 keypad scanner.
// Latency: none; types, constants and helper functions only.
// Backpressure: not applicable.
package keypad_pkg;

    localparam int N_ROW = 4;
    localparam int N_COL = 4;
    localparam int KEY_W = 4;
    localparam int IDX_W = 2;

    localparam logic [N_COL-1:0] COL_RST = 4'b1110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    // Lowest-index active-low row; caller guarantees at least one row is low.
    function automatic logic [IDX_W-1:0] low_row(input logic [N_ROW-1:0] rows_n);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int r = N_ROW - 1; r >= 0; r--) begin
            if (!rows_n[r]) begin
                idx = IDX_W'(r);
            end
        end
        return idx;
    endfunction

    function automatic logic [N_COL-1:0] col_drive(input logic [IDX_W-1:0] idx);
        return ~(N_COL'(1) << idx);
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer; resets to all-ones so idle pulled-up inputs read inactive.
// Latency: 2 clocks.
// Backpressure: none.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with press/release debounce; KEYPAD_REPEAT_EN adds auto-repeat.
// Latency: 2-clock row sync, then DEBOUNCE_CYC stable clocks before the valid strobe.
// Backpressure: none; valid is a one-cycle strobe the consumer must take when it fires.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 20000
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_DLY   = 500000,
    parameter int REPEAT_PER   = 100000
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_ROW-1:0] row_n,
    output logic [N_COL-1:0] col_n,
    output logic [KEY_W-1:0] key,
    output logic             valid,
    output logic             held
);

    localparam int DW = $clog2(SCAN_DIV) + 1;
    localparam int BW = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_DONE    = BW'(DEBOUNCE_CYC);

    logic [N_ROW-1:0] row_s;

    state_t           state_q,   state_d;
    logic [IDX_W-1:0] col_idx_q, col_idx_d;
    logic [IDX_W-1:0] row_q,     row_d;
    logic [DW-1:0]    dwell_q,   dwell_d;
    logic [BW-1:0]    db_q,      db_d;
    logic [BW-1:0]    db_inc;
    logic [N_COL-1:0] col_n_q,   col_n_d;
    logic [KEY_W-1:0] key_q,     key_d;
    logic             valid_q,   valid_d;
    logic             held_q,    held_d;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW      = $clog2(RPT_MAX) + 1;
    localparam logic [RW-1:0] RPT_DLY_C = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] RPT_PER_C = RW'(REPEAT_PER);

    logic [RW-1:0] rpt_q, rpt_d;
    logic [RW-1:0] rpt_inc;
    // High until the first (longer) repeat interval has elapsed for this press.
    logic          rpt_first_q, rpt_first_d;
`endif

    sync2 #(.W(N_ROW)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (row_s)
    );

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_d     = row_q;
        dwell_d   = dwell_q;
        db_d      = db_q;
        key_d     = key_q;
        valid_d   = 1'b0;
        held_d    = held_q;
        db_inc    = (db_q == DB_DONE) ? db_q : db_q + BW'(1);
`ifdef KEYPAD_REPEAT_EN
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
        rpt_inc     = (rpt_q == '1) ? rpt_q : rpt_q + RW'(1);
`endif

        unique case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (row_s != '1) begin
                        row_d   = low_row(row_s);
                        db_d    = '0;
                        state_d = PRESS_DB;
                    end else begin
                        col_idx_d = col_idx_q + IDX_W'(1);
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end

            PRESS_DB: begin
                if (row_s[row_q]) begin
                    dwell_d = '0;
                    state_d = SCAN;
                end else begin
                    db_d = db_inc;
                    if (db_inc == DB_DONE) begin
                        key_d   = {row_q, col_idx_q};
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                        rpt_d       = '0;
                        rpt_first_d = 1'b1;
`endif
                    end
                end
            end

            HELD: begin
                if (row_s[row_q]) begin
                    db_d    = '0;
                    state_d = REL_DB;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    rpt_d = rpt_inc;
                    if (rpt_inc == (rpt_first_q ? RPT_DLY_C : RPT_PER_C)) begin
                        valid_d     = 1'b1;
                        rpt_d       = '0;
                        rpt_first_d = 1'b0;
                    end
`endif
                end
            end

            REL_DB: begin
                // The repeat counter is left untouched here so a release glitch resumes it.
                if (!row_s[row_q]) begin
                    state_d = HELD;
                end else begin
                    db_d = db_inc;
                    if (db_inc == DB_DONE) begin
                        held_d    = 1'b0;
                        col_idx_d = col_idx_q + IDX_W'(1);
                        dwell_d   = '0;
                        state_d   = SCAN;
                    end
                end
            end

            default: state_d = SCAN;
        endcase

        col_n_d = col_drive(col_idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            col_idx_q <= '0;
            row_q     <= '0;
            dwell_q   <= '0;
            db_q      <= '0;
            col_n_q   <= COL_RST;
            key_q     <= '0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_q     <= row_d;
            dwell_q   <= dwell_d;
            db_q      <= db_d;
            col_n_q   <= col_n_d;
            key_q     <= key_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`endif

    assign col_n = col_n_q;
    assign key   = key_q;
    assign valid = valid_q;
    assign held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CYC=8 and a resistive keypad model.
// Honours KEYPAD_REPEAT_EN (REPEAT_DLY=40, REPEAT_PER=10) when the macro is defined.
`timescale 1ns/1ps
module tb_keypad_scan;
    import keypad_pkg::*;

`ifdef KEYPAD_REPEAT_EN
    localparam int HOLD50_EXTRA = 2;
`else
    localparam int HOLD50_EXTRA = 0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key;
    logic        valid;
    logic        held;
    logic [15:0] keys  = '0;

    int n_chk  = 0;
    int n_pass = 0;
    int vcnt   = 0;
    int v0     = 0;

    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low only while column c is driven low.
    always_comb begin
        row_n = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) begin
                    row_n[r] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid) begin
            vcnt++;
        end
    end

    keypad_scan #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CYC (8)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DLY   (40),
        .REPEAT_PER   (10)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .row_n (row_n),
        .col_n (col_n),
        .key   (key),
        .valid (valid),
        .held  (held)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int i;
        i = 0;
        do begin
            step(1);
            i++;
        end while (!valid && i < budget);
        check(tag, int'(valid), 1);
    endtask

    task automatic wait_held_low(input string tag, input int budget);
        int i;
        i = 0;
        while (held && i < budget) begin
            step(1);
            i++;
        end
        check(tag, int'(held), 0);
    endtask

    // Leaves the bench on the first cycle column c is driven after a column change.
    task automatic wait_col_start(input string tag, input logic [3:0] c);
        int i;
        i = 0;
        while (col_n == c && i < 40) begin
            step(1);
            i++;
        end
        i = 0;
        while (col_n != c && i < 40) begin
            step(1);
            i++;
        end
        check(tag, int'(col_n), int'(c));
    endtask

    initial begin
        // Reset and idle scanning.
        #1 rst_n = 1'b0;
        #1;
        check("rst_col_n", int'(col_n), 'b1110);
        check("rst_key",   int'(key),   0);
        check("rst_valid", int'(valid), 0);
        check("rst_held",  int'(held),  0);
        #20 rst_n = 1'b1;
        step(1);
        step(3);
        for (int j = 0; j < 8; j++) begin
            check("idle_col_n", int'(col_n), int'(col_drive(2'((j + 1) % 4))));
            step(4);
        end
        check("idle_no_valid", vcnt, 0);
        check("idle_key", int'(key), 0);

        // Single press of (2,1), held 50 clocks.
        v0 = vcnt;
        keys[9] = 1'b1;
        wait_valid("k9_valid_seen", 60);
        check("k9_key",  int'(key),  9);
        check("k9_held", int'(held), 1);
        step(50);
        check("k9_hold_count", vcnt, v0 + 1 + HOLD50_EXTRA);
        check("k9_hold_held",  int'(held), 1);
        keys[9] = 1'b0;
        step(10);
        check("k9_rel_held_hi", int'(held), 1);
        step(1);
        check("k9_rel_held_lo", int'(held), 0);
        check("k9_next_col",    int'(col_n), 'b1011);
        check("k9_total",       vcnt, v0 + 1 + HOLD50_EXTRA);

        // Bounce on (1,2) while in press debounce, then steady.
        wait_col_start("b6_col", 4'b1011);
        v0 = vcnt;
        keys[6] = 1'b1;
        step(6);
        keys[6] = 1'b0;
        step(2);
        keys[6] = 1'b1;
        step(12);
        check("b6_no_early", vcnt, v0);
        step(1);
        check("b6_valid", int'(valid), 1);
        check("b6_key",   int'(key),   6);
        keys[6] = 1'b0;
        wait_held_low("b6_release", 20);
        check("b6_count", vcnt, v0 + 1);

        // Two keys: (0,3) accepted, (1,0) pressed while held.
        v0 = vcnt;
        keys[3] = 1'b1;
        wait_valid("m3_valid_seen", 60);
        check("m3_key", int'(key), 3);
        keys[4] = 1'b1;
        step(20);
        check("m_both_no_valid", vcnt, v0 + 1);
        check("m_col_frozen", int'(col_n), 'b0111);
        check("m_key_kept", int'(key), 3);
        keys[3] = 1'b0;
        wait_held_low("m3_release", 20);
        wait_valid("m4_valid_seen", 60);
        check("m4_key", int'(key), 4);
        check("m_count", vcnt, v0 + 2);
        keys[4] = 1'b0;
        wait_held_low("m4_release", 20);

        // Reset while press debounce count is 5 on key (3,0).
        wait_col_start("r12_col", 4'b1110);
        v0 = vcnt;
        keys[12] = 1'b1;
        step(9);
        #2 rst_n = 1'b0;
        #1;
        check("r_async_col_n", int'(col_n), 'b1110);
        check("r_async_key",   int'(key),   0);
        check("r_async_valid", int'(valid), 0);
        check("r_async_held",  int'(held),  0);
        keys[12] = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(30);
        check("r_no_valid", vcnt, v0);
        wait_col_start("r12_col2", 4'b1110);
        keys[12] = 1'b1;
        step(11);
        check("r_fresh_not_yet", int'(valid), 0);
        step(1);
        check("r_fresh_valid", int'(valid), 1);
        check("r_fresh_key",   int'(key),   12);
        keys[12] = 1'b0;
        wait_held_low("r12_release", 20);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat on key 7, held 80 clocks after the first strobe.
        v0 = vcnt;
        keys[7] = 1'b1;
        wait_valid("rp7_valid_seen", 60);
        check("rp7_key", int'(key), 7);
        for (int k = 1; k <= 80; k++) begin
            step(1);
            check("rp7_pulse", int'(valid), (k >= 40 && k % 10 == 0) ? 1 : 0);
            if (k >= 40 && k % 10 == 0) begin
                check("rp7_pulse_key", int'(key), 7);
            end
        end
        keys[7] = 1'b0;
        wait_held_low("rp7_release", 20);
        step(20);
        check("rp7_count", vcnt, v0 + 6);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
